// File: rtl/snake_plot_scheduler.sv
`timescale 1ns/1ps
// Round-robin scheduler that rasters one requester's DIM x DIM box at a time onto the
// single-pixel VGA adapter plot port.
module snake_plot_scheduler #(
    parameter int unsigned DIM     = 10,
    parameter int unsigned XSCREEN = 160,
    parameter int unsigned YSCREEN = 120
) (
    input  logic        CLOCK_50,
    input  logic        Resetn,
    input  logic [2:0]  req,
    input  logic [23:0] x_in,
    input  logic [20:0] y_in,
    input  logic [8:0]  colour_in,
    output logic [2:0]  ack,
    output logic [2:0]  done,
    output logic        busy,
    output logic [7:0]  VGA_X,
    output logic [6:0]  VGA_Y,
    output logic [2:0]  VGA_COLOR,
    output logic        plot
);

    localparam logic [3:0] CntLast = 4'(DIM - 1);
    localparam logic [8:0] XLim    = 9'(XSCREEN);
    localparam logic [7:0] YLim    = 8'(YSCREEN);

    typedef enum logic [1:0] {StIdle, StLoad, StDraw, StFin} state_e;

    state_e      state_q, state_d;
    logic [1:0]  last_q, grant_q, winner;
    logic [7:0]  xbase_q, sel_x;
    logic [6:0]  ybase_q, sel_y;
    logic [2:0]  cbase_q, sel_c;
    logic [3:0]  xc_q, yc_q;
    logic [8:0]  xsum;
    logic [7:0]  ysum;
    logic        box_end;

    assign box_end = (xc_q == CntLast) && (yc_q == CntLast);

    // Search starts just after the previous grant and wraps around to it last.
    always_comb begin
        winner = 2'd0;
        case (last_q)
            2'd0:    winner = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    winner = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: winner = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_comb begin
        sel_x = x_in[7:0];
        sel_y = y_in[6:0];
        sel_c = colour_in[2:0];
        case (winner)
            2'd1: begin
                sel_x = x_in[15:8];
                sel_y = y_in[13:7];
                sel_c = colour_in[5:3];
            end
            2'd2: begin
                sel_x = x_in[23:16];
                sel_y = y_in[20:14];
                sel_c = colour_in[8:6];
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (req != 3'b000) state_d = StLoad;
            StLoad:  state_d = StDraw;
            StDraw:  if (box_end) state_d = StFin;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            last_q  <= 2'd2;
            grant_q <= 2'd0;
            xbase_q <= '0;
            ybase_q <= '0;
            cbase_q <= '0;
            xc_q    <= '0;
            yc_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req != 3'b000) begin
                        grant_q <= winner;
                        xbase_q <= sel_x;
                        ybase_q <= sel_y;
                        cbase_q <= sel_c;
                        xc_q    <= '0;
                        yc_q    <= '0;
                    end
                end
                StDraw: begin
                    if (xc_q == CntLast) begin
                        xc_q <= '0;
                        yc_q <= yc_q + 4'd1;
                    end else begin
                        xc_q <= xc_q + 4'd1;
                    end
                end
                StFin:   last_q <= grant_q;
                default: ;
            endcase
        end
    end

    // Sums are one bit wider than the port so off-screen pixels can be detected.
    assign xsum = {1'b0, xbase_q} + {5'b0, xc_q};
    assign ysum = {1'b0, ybase_q} + {4'b0, yc_q};

    always_comb begin
        ack       = (state_q == StLoad) ? (3'b001 << grant_q) : 3'b000;
        done      = (state_q == StFin) ? (3'b001 << grant_q) : 3'b000;
        busy      = (state_q != StIdle);
        plot      = (state_q == StDraw) && (xsum < XLim) && (ysum < YLim);
        VGA_X     = xsum[7:0];
        VGA_Y     = ysum[6:0];
        VGA_COLOR = cbase_q;
    end

endmodule
